spi_xfer_scheduler: RTL and testbench
=====================================

// Module: spi_xfer_scheduler
// PURPOSE
//  Shares the single spi_module instance between NUM_REQ independent requesters.
//  - Arbitrates round-robin between requesters.
//  - Programs the granted requester's config word and tx data, pulses trans_en,
//    waits for the SPI completion interrupt, and returns rx data to the winner.
//  - Sits between the system-side clients and the spi_module config/data/trans_en/interrupt pins.
// PARAMETERS
//  NUM_REQ    2     number of requesters (2..8)
//  DATA_W     8     SPI parallel data width (i_data/o_data of spi_module)
//  CFG_W      32    config word width {C1,C2,STATUS,BAUD}
//  SETUP_CYC  2     cycles config/data held stable before trans_en pulse (>=1)
//  TIMEOUT    4096  max cycles waiting for interrupt before abort (>=2)
// PORTS
//  i_sys_clk        in   1               system clock, all logic on rising edge
//  i_sys_rst        in   1               asynchronous reset, active-high
//  i_req            in   NUM_REQ         per-requester transfer request (level, held until o_done)
//  i_req_cfg        in   NUM_REQ*CFG_W   per-requester config word, slice k = requester k
//  i_req_data       in   NUM_REQ*DATA_W  per-requester tx data, slice k = requester k
//  o_gnt            out  NUM_REQ         one-hot grant, high from CFG through RESP
//  o_done           out  NUM_REQ         one-cycle completion pulse to granted requester
//  o_err            out  1               one-cycle pulse with o_done when transfer timed out
//  o_rx_data        out  DATA_W          received data, valid in the o_done cycle, held after
//  o_busy           out  1               high whenever state != IDLE
//  o_spi_config     out  CFG_W           to spi_module i_data_config
//  o_spi_data       out  DATA_W          to spi_module i_data
//  o_spi_trans_en   out  1               to spi_module i_trans_en, one-cycle pulse
//  i_spi_interrupt  in   1               from spi_module o_interrupt
//  i_spi_data       in   DATA_W          from spi_module o_data
// BEHAVIOUR
//  Reset: state=IDLE; o_gnt, o_done, o_err, o_spi_trans_en, o_busy = 0.
//    o_rx_data, o_spi_config, o_spi_data = 0; RR pointer = 0; timeout counter = 0.
//  FSM (all outputs registered):
//    IDLE  -> CFG when any i_req. Winner = first set bit at or after RR pointer (wrapping).
//    CFG   o_gnt[w]=1; latch i_req_cfg[w]/i_req_data[w] into o_spi_config/o_spi_data
//          on entry; hold SETUP_CYC cycles -> START.
//    START o_spi_trans_en=1 for exactly one cycle -> WAIT.
//    WAIT  count cycles. On rising edge of i_spi_interrupt (registered edge detect)
//          capture i_spi_data -> RESP. Counter reaching TIMEOUT-1 -> RESP with err, o_rx_data=0.
//    RESP  o_done[w]=1 and o_err as applicable, both for one cycle.
//          RR pointer = (w+1) mod NUM_REQ -> IDLE.
//  Latency: i_req seen in IDLE at cycle N -> o_gnt at N+1, trans_en at N+1+SETUP_CYC.
//    Minimum turnaround RESP->next CFG is 2 cycles (RESP, IDLE).
//  o_spi_config/o_spi_data change only on CFG entry; stable through WAIT/RESP and IDLE.
//  Interrupt edges outside WAIT are ignored; edge detector runs continuously.
//    An interrupt already high at WAIT entry does not complete the transfer.
//  Winner dropping i_req after grant does not abort; transfer completes normally.
//  Requests arriving while busy are held off; no request is lost while i_req is held.
//  Simultaneous requests: RR order only; no fixed priority. Pointer moves only at RESP.
//  Reset mid-transfer: immediate return to IDLE, o_spi_trans_en=0;
//    spi_module is reset by the same i_sys_rst.
// STRUCTURE
//  Package spi_sched_pkg:
//    - state enum {IDLE,CFG,START,WAIT,RESP}
//    - CFG_W default localparam
//    - function clog2-based counter widths for TIMEOUT/SETUP_CYC
//  Sub-module rr_arbiter (NUM_REQ): combinational req+pointer -> one-hot grant + index.
//    Pointer register stays in the scheduler.
// TESTING
//  1 Single req[0], cfg=32'hD610_8011, data=8'hA5, loopback slave returns 8'h3C
//    -> trans_en exactly 3 cycles after req (SETUP_CYC=2); o_done[0] one cycle;
//    o_rx_data=8'h3C; o_err=0.
//  2 req=2'b11 held continuously, 4 transfers -> grant order 0,1,0,1;
//    each o_spi_config matches the owner's slice.
//  3 Interrupt forced low (slave absent), TIMEOUT=64
//    -> o_done+o_err 64 cycles after WAIT entry, o_rx_data=0, back to IDLE.
//  4 Assert i_sys_rst during WAIT
//    -> same cycle o_busy=0, o_gnt=0, trans_en=0; next req served from pointer 0.
//  5 req[1] dropped one cycle after grant; spurious interrupt pulse during CFG
//    -> transfer still completes on the real interrupt; spurious pulse ignored.
//  6 Check config/data stability: o_spi_config/o_spi_data constant from CFG+1 to RESP
//    while i_req_cfg toggles every cycle.

Source files
------------

// File: rtl/spi_sched_pkg.sv
// spi_sched_pkg: shared types and sizing helpers for the SPI transfer scheduler
package spi_sched_pkg;
  typedef enum logic [2:0] {IDLE, CFG, START, WAIT, RESP} state_e;
  localparam int CFG_W_DEF = 32;
  function automatic int cnt_w(input int timeout, input int setup);
    return $clog2((timeout > setup ? timeout : setup) + 1);
  endfunction
endpackage

// File: rtl/spi_xfer_scheduler_if.sv
// spi_xfer_scheduler_if: requester-side and spi_module-side signals of the scheduler
interface spi_xfer_scheduler_if import spi_sched_pkg::*; #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 8,
  parameter int CFG_W   = CFG_W_DEF
);
  logic [NUM_REQ-1:0]        i_req, o_gnt, o_done;
  logic [NUM_REQ*CFG_W-1:0]  i_req_cfg;
  logic [NUM_REQ*DATA_W-1:0] i_req_data;
  logic [DATA_W-1:0]         o_rx_data, o_spi_data, i_spi_data;
  logic [CFG_W-1:0]          o_spi_config;
  logic                      o_err, o_busy, o_spi_trans_en, i_spi_interrupt;
  modport slave (
    input  i_req, i_req_cfg, i_req_data, i_spi_interrupt, i_spi_data,
    output o_gnt, o_done, o_err, o_rx_data, o_busy, o_spi_config, o_spi_data, o_spi_trans_en
  );
  modport master (
    output i_req, i_req_cfg, i_req_data, i_spi_interrupt, i_spi_data,
    input  o_gnt, o_done, o_err, o_rx_data, o_busy, o_spi_config, o_spi_data, o_spi_trans_en
  );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: first request at or after ptr_i (wrapping) wins, one-hot plus index
module rr_arbiter #(
  parameter int NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0]         req_i,
  input  logic [$clog2(NUM_REQ)-1:0] ptr_i,
  output logic [NUM_REQ-1:0]         gnt_o,
  output logic [$clog2(NUM_REQ)-1:0] idx_o
);
  int k;
  // scanning backwards lets the closest request to the pointer overwrite the others
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    k = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      k = (int'(ptr_i) + i) % NUM_REQ;
      if (req_i[k]) begin
        gnt_o = NUM_REQ'(1) << k;
        idx_o = $clog2(NUM_REQ)'(k);
      end
    end
  end
endmodule

// File: rtl/spi_xfer_scheduler.sv
// spi_xfer_scheduler: round-robin sharing of one spi_module between NUM_REQ requesters
module spi_xfer_scheduler import spi_sched_pkg::*; #(
  parameter int NUM_REQ   = 2,
  parameter int DATA_W    = 8,
  parameter int CFG_W     = CFG_W_DEF,
  parameter int SETUP_CYC = 2,
  parameter int TIMEOUT   = 4096
) (
  input  logic i_sys_clk,
  input  logic i_sys_rst,
  spi_xfer_scheduler_if.slave bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = cnt_w(TIMEOUT, SETUP_CYC);
  state_e state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d, idx_q, idx_d, arb_idx;
  logic [NUM_REQ-1:0] gnt_q, gnt_d, done_q, done_d, arb_gnt;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CFG_W-1:0] cfg_q, cfg_d;
  logic [DATA_W-1:0] dat_q, dat_d, rx_q, rx_d;
  logic err_q, err_d, ten_q, ten_d, busy_q, busy_d, irq_q, irq_rise;
  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req_i(bus.i_req), .ptr_i(ptr_q), .gnt_o(arb_gnt), .idx_o(arb_idx)
  );
  assign irq_rise = bus.i_spi_interrupt & ~irq_q;
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    cfg_d   = cfg_q;
    dat_d   = dat_q;
    rx_d    = rx_q;
    done_d  = '0;
    err_d   = 1'b0;
    ten_d   = 1'b0;
    case (state_q)
      IDLE: if (|bus.i_req) begin
        state_d = CFG;
        idx_d   = arb_idx;
        gnt_d   = arb_gnt;
        cnt_d   = '0;
        cfg_d   = bus.i_req_cfg[arb_idx*CFG_W +: CFG_W];
        dat_d   = bus.i_req_data[arb_idx*DATA_W +: DATA_W];
      end
      CFG: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(SETUP_CYC - 1)) begin
          state_d = START;
          ten_d   = 1'b1;
        end
      end
      START: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        if (irq_rise || cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = RESP;
          done_d  = gnt_q;
          err_d   = ~irq_rise;
          rx_d    = irq_rise ? bus.i_spi_data : '0;
        end
      end
      RESP: begin
        state_d = IDLE;
        gnt_d   = '0;
        ptr_d   = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge i_sys_clk or posedge i_sys_rst) begin
    if (i_sys_rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      cfg_q   <= '0;
      dat_q   <= '0;
      rx_q    <= '0;
      err_q   <= 1'b0;
      ten_q   <= 1'b0;
      busy_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      cfg_q   <= cfg_d;
      dat_q   <= dat_d;
      rx_q    <= rx_d;
      err_q   <= err_d;
      ten_q   <= ten_d;
      busy_q  <= busy_d;
      irq_q   <= bus.i_spi_interrupt;
    end
  end
  assign bus.o_gnt          = gnt_q;
  assign bus.o_done         = done_q;
  assign bus.o_err          = err_q;
  assign bus.o_rx_data      = rx_q;
  assign bus.o_busy         = busy_q;
  assign bus.o_spi_config   = cfg_q;
  assign bus.o_spi_data     = dat_q;
  assign bus.o_spi_trans_en = ten_q;
endmodule

// File: tb/tb_spi_xfer_scheduler.sv
// tb_spi_xfer_scheduler: directed table-driven checks of the SPI transfer scheduler
module tb_spi_xfer_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  spi_xfer_scheduler_if #(.NUM_REQ(2), .DATA_W(8), .CFG_W(32)) bus ();
  spi_xfer_scheduler #(.NUM_REQ(2), .DATA_W(8), .CFG_W(32), .SETUP_CYC(2), .TIMEOUT(64)) dut (
    .i_sys_clk(clk), .i_sys_rst(rst), .bus(bus)
  );
  typedef struct {
    logic [1:0]  req;
    logic [31:0] cfg0, cfg1;
    logic [7:0]  d0, d1;
    int          dly;
    logic [7:0]  rx;
    logic [1:0]  gnt;
    logic [31:0] ecfg;
    logic [7:0]  edat;
    logic        err;
    logic [7:0]  erx;
  } vec_t;
  vec_t vt[8];
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  // Starts in an IDLE cycle and ends in the IDLE cycle after RESP.
  task automatic run_vec(input vec_t v, input int n);
    bus.i_req = v.req;
    bus.i_req_cfg = {v.cfg1, v.cfg0};
    bus.i_req_data = {v.d1, v.d0};
    bus.i_spi_data = v.rx;
    bus.i_spi_interrupt = 1'b0;
    tick();
    chk($sformatf("v%0d gnt", n), bus.o_gnt, v.gnt);
    chk($sformatf("v%0d busy", n), bus.o_busy, 1);
    chk($sformatf("v%0d ten early", n), bus.o_spi_trans_en, 0);
    tick();
    chk($sformatf("v%0d cfg", n), bus.o_spi_config, v.ecfg);
    chk($sformatf("v%0d data", n), bus.o_spi_data, v.edat);
    chk($sformatf("v%0d ten early2", n), bus.o_spi_trans_en, 0);
    tick();
    chk($sformatf("v%0d ten", n), bus.o_spi_trans_en, 1);
    tick();
    chk($sformatf("v%0d ten pulse", n), bus.o_spi_trans_en, 0);
    if (v.dly >= 0) begin
      repeat (v.dly) tick();
      bus.i_spi_interrupt = 1'b1;
      tick();
    end else begin
      repeat (63) tick();
      chk($sformatf("v%0d early done", n), bus.o_done, 0);
      tick();
    end
    chk($sformatf("v%0d done", n), bus.o_done, v.gnt);
    chk($sformatf("v%0d err", n), bus.o_err, v.err);
    chk($sformatf("v%0d rx", n), bus.o_rx_data, v.erx);
    chk($sformatf("v%0d gnt resp", n), bus.o_gnt, v.gnt);
    bus.i_spi_interrupt = 1'b0;
    tick();
    chk($sformatf("v%0d done pulse", n), bus.o_done, 0);
    chk($sformatf("v%0d err pulse", n), bus.o_err, 0);
    chk($sformatf("v%0d idle busy", n), bus.o_busy, 0);
    chk($sformatf("v%0d idle gnt", n), bus.o_gnt, 0);
    chk($sformatf("v%0d rx held", n), bus.o_rx_data, v.erx);
    chk($sformatf("v%0d cfg held", n), bus.o_spi_config, v.ecfg);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.i_req = '0;
    bus.i_req_cfg = '0;
    bus.i_req_data = '0;
    bus.i_spi_interrupt = 1'b0;
    bus.i_spi_data = '0;
    vt[0] = '{2'b01, 32'hD610_8011, 32'h1111_1111, 8'hA5, 8'h11, 2, 8'h3C, 2'b01, 32'hD610_8011, 8'hA5, 1'b0, 8'h3C};
    vt[1] = '{2'b10, 32'h2222_2222, 32'h0BAD_CAFE, 8'h22, 8'h5A, 0, 8'h81, 2'b10, 32'h0BAD_CAFE, 8'h5A, 1'b0, 8'h81};
    vt[2] = '{2'b11, 32'hA0A0_0001, 32'hB0B0_0002, 8'h01, 8'h02, 5, 8'h11, 2'b01, 32'hA0A0_0001, 8'h01, 1'b0, 8'h11};
    vt[3] = '{2'b11, 32'hA0A0_0003, 32'hB0B0_0004, 8'h03, 8'h04, 1, 8'h22, 2'b10, 32'hB0B0_0004, 8'h04, 1'b0, 8'h22};
    vt[4] = '{2'b11, 32'hA0A0_0005, 32'hB0B0_0006, 8'h05, 8'h06, 7, 8'h33, 2'b01, 32'hA0A0_0005, 8'h05, 1'b0, 8'h33};
    vt[5] = '{2'b11, 32'hA0A0_0007, 32'hB0B0_0008, 8'h07, 8'h08, 3, 8'h44, 2'b10, 32'hB0B0_0008, 8'h08, 1'b0, 8'h44};
    vt[6] = '{2'b10, 32'h0000_0000, 32'hDEAD_BEEF, 8'h00, 8'h77, -1, 8'hFF, 2'b10, 32'hDEAD_BEEF, 8'h77, 1'b1, 8'h00};
    vt[7] = '{2'b01, 32'h1357_9BDF, 32'h0000_0000, 8'hE7, 8'h00, 0, 8'h99, 2'b01, 32'h1357_9BDF, 8'hE7, 1'b0, 8'h99};
    tick();
    tick();
    chk("rst gnt", bus.o_gnt, 0);
    chk("rst done", bus.o_done, 0);
    chk("rst err", bus.o_err, 0);
    chk("rst busy", bus.o_busy, 0);
    chk("rst ten", bus.o_spi_trans_en, 0);
    chk("rst rx", bus.o_rx_data, 0);
    chk("rst cfg", bus.o_spi_config, 0);
    chk("rst data", bus.o_spi_data, 0);
    rst = 1'b0;
    for (int n = 0; n < 8; n++) run_vec(vt[n], n);
    // reset in WAIT while pointer sits at 1; next contested request must go to 0
    bus.i_req = 2'b10;
    bus.i_req_cfg = {32'hFACE_0001, 32'hFACE_0000};
    repeat (6) tick();
    chk("t4 pre busy", bus.o_busy, 1);
    chk("t4 pre gnt", bus.o_gnt, 2'b10);
    rst = 1'b1;
    #1;
    chk("t4 rst busy", bus.o_busy, 0);
    chk("t4 rst gnt", bus.o_gnt, 0);
    chk("t4 rst ten", bus.o_spi_trans_en, 0);
    chk("t4 rst cfg", bus.o_spi_config, 0);
    bus.i_req = '0;
    tick();
    rst = 1'b0;
    bus.i_req = 2'b11;
    tick();
    chk("t4 ptr0 gnt", bus.o_gnt, 2'b01);
    repeat (3) tick();
    bus.i_spi_data = 8'h5D;
    bus.i_spi_interrupt = 1'b1;
    tick();
    chk("t4 done", bus.o_done, 2'b01);
    chk("t4 rx", bus.o_rx_data, 8'h5D);
    bus.i_spi_interrupt = 1'b0;
    bus.i_req = '0;
    tick();
    // requester drops after grant; spurious CFG pulse and a level already high at WAIT entry
    bus.i_req = 2'b10;
    bus.i_req_cfg = {32'h0000_C0DE, 32'h0};
    bus.i_req_data = {8'h6E, 8'h00};
    bus.i_spi_data = 8'hC3;
    tick();
    chk("t5 gnt", bus.o_gnt, 2'b10);
    bus.i_spi_interrupt = 1'b1;
    tick();
    bus.i_req = '0;
    bus.i_spi_interrupt = 1'b0;
    tick();
    chk("t5 ten", bus.o_spi_trans_en, 1);
    bus.i_spi_interrupt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("t5 no done %0d", i), bus.o_done, 0);
      chk($sformatf("t5 gnt held %0d", i), bus.o_gnt, 2'b10);
    end
    bus.i_spi_interrupt = 1'b0;
    tick();
    bus.i_spi_interrupt = 1'b1;
    tick();
    chk("t5 done", bus.o_done, 2'b10);
    chk("t5 err", bus.o_err, 0);
    chk("t5 rx", bus.o_rx_data, 8'hC3);
    chk("t5 data", bus.o_spi_data, 8'h6E);
    bus.i_spi_interrupt = 1'b0;
    tick();
    chk("t5 idle", bus.o_busy, 0);
    // config/data inputs toggle every cycle while a transfer is in flight
    bus.i_req = 2'b01;
    bus.i_req_cfg = {32'h0, 32'hC0FF_EE00};
    bus.i_req_data = {8'h00, 8'h5C};
    bus.i_spi_data = 8'h12;
    tick();
    chk("t6 cfg", bus.o_spi_config, 32'hC0FF_EE00);
    chk("t6 data", bus.o_spi_data, 8'h5C);
    for (int i = 0; i < 5; i++) begin
      bus.i_req_cfg = ~bus.i_req_cfg;
      bus.i_req_data = ~bus.i_req_data;
      tick();
      chk($sformatf("t6 cfg stable %0d", i), bus.o_spi_config, 32'hC0FF_EE00);
      chk($sformatf("t6 data stable %0d", i), bus.o_spi_data, 8'h5C);
    end
    bus.i_spi_interrupt = 1'b1;
    bus.i_req_cfg = ~bus.i_req_cfg;
    tick();
    chk("t6 done", bus.o_done, 2'b01);
    chk("t6 rx", bus.o_rx_data, 8'h12);
    chk("t6 cfg resp", bus.o_spi_config, 32'hC0FF_EE00);
    bus.i_spi_interrupt = 1'b0;
    bus.i_req = '0;
    tick();
    chk("t6 cfg idle", bus.o_spi_config, 32'hC0FF_EE00);
    chk("t6 data idle", bus.o_spi_data, 8'h5C);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
